// File: rtl/song_play_ctrl.sv
// rtl/song_play_ctrl.sv - AUTOPLAY sequencer: walks a song's note ROM and times note, rest and gap periods
module song_play_ctrl #(
    parameter int         IDX_W      = 9,
    parameter int         BEAT_UNIT  = 1600,
    parameter int         GAP_CYCLES = 2800,
    parameter logic [2:0] PLAY_STATE = 3'b010
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           state,
    input  logic [7:0]           song_id,
    input  logic [IDX_W-1:0]     song_len,
    input  logic                 start,
    input  logic                 pause,
    output logic [8+IDX_W-1:0]   rom_addr,
    input  logic [7:0]           rom_data,
    output logic [4:0]           note,
    output logic                 note_on,
    output logic                 busy,
    output logic [IDX_W-1:0]     note_idx,
    output logic                 done
);

    localparam int UNIT_W = (BEAT_UNIT > 1) ? $clog2(BEAT_UNIT) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [UNIT_W-1:0] UNIT_RELOAD = UNIT_W'(BEAT_UNIT - 1);
    localparam logic [GAP_W-1:0]  GAP_RELOAD  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } fsm_t;

    fsm_t              fsm, fsm_nxt;
    logic [7:0]        song_id_q;
    logic [IDX_W-1:0]  song_len_q;
    logic [IDX_W-1:0]  note_idx_q;
    logic [IDX_W-1:0]  idx_inc;
    logic [4:0]        note_code;
    logic [2:0]        units_left;
    logic [UNIT_W-1:0] unit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              start_ok;
    logic              abort;
    logic              play_end;
    logic              gap_end;

    assign idx_inc  = note_idx_q + IDX_W'(1);
    assign start_ok = start && (state == PLAY_STATE);
    assign abort    = (fsm != S_IDLE) && (state != PLAY_STATE);
    assign play_end = !pause && (unit_cnt == '0) && (units_left == 3'd0);
    assign gap_end  = !pause && (gap_cnt == '0);

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            S_IDLE:  if (start_ok) fsm_nxt = (song_len == '0) ? S_DONE : S_FETCH;
            S_FETCH: fsm_nxt = S_LOAD;
            S_LOAD:  fsm_nxt = S_PLAY;
            S_PLAY:  if (play_end) fsm_nxt = S_GAP;
            S_GAP:   if (gap_end) fsm_nxt = (idx_inc == song_len_q) ? S_DONE : S_FETCH;
            S_DONE:  fsm_nxt = S_IDLE;
            default: fsm_nxt = S_IDLE;
        endcase
        // Leaving AUTOPLAY wins over pause and over any normal transition
        if (abort) fsm_nxt = S_IDLE;
    end

    always_comb begin
        rom_addr = {song_id_q, note_idx_q};
        note     = 5'd0;
        note_on  = 1'b0;
        busy     = (fsm != S_IDLE);
        done     = (fsm == S_DONE);
        note_idx = note_idx_q;
        if (fsm == S_PLAY || fsm == S_GAP) note = note_code;
        if (fsm == S_PLAY) note_on = (note_code != 5'd0) && !pause;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= S_IDLE;
            song_id_q  <= 8'd0;
            song_len_q <= '0;
            note_idx_q <= '0;
            note_code  <= 5'd0;
            units_left <= 3'd0;
            unit_cnt   <= '0;
            gap_cnt    <= '0;
        end else begin
            fsm <= fsm_nxt;
            if (abort) begin
                note_idx_q <= '0;
                note_code  <= 5'd0;
            end else begin
                case (fsm)
                    S_IDLE: begin
                        if (start_ok) begin
                            song_id_q  <= song_id;
                            song_len_q <= song_len;
                            note_idx_q <= '0;
                        end
                    end
                    S_LOAD: begin
                        note_code  <= rom_data[7:3];
                        units_left <= rom_data[2:0];
                        unit_cnt   <= UNIT_RELOAD;
                    end
                    S_PLAY: begin
                        // Each length unit is one full BEAT_UNIT period; len_code+1 units in total
                        if (!pause) begin
                            if (unit_cnt != '0) begin
                                unit_cnt <= unit_cnt - UNIT_W'(1);
                            end else if (units_left != 3'd0) begin
                                units_left <= units_left - 3'd1;
                                unit_cnt   <= UNIT_RELOAD;
                            end else begin
                                gap_cnt <= GAP_RELOAD;
                            end
                        end
                    end
                    S_GAP: begin
                        if (!pause) begin
                            if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
                            else               note_idx_q <= idx_inc;
                        end
                    end
                    S_DONE: note_idx_q <= '0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_play_ctrl.sv
// tb/tb_song_play_ctrl.sv - directed self-checking bench for song_play_ctrl
module tb_song_play_ctrl;

    localparam int IDX_W = 9;

    logic               clk;
    logic               rst;
    logic [2:0]         state;
    logic [7:0]         song_id;
    logic [IDX_W-1:0]   song_len;
    logic               start;
    logic               pause;
    logic [8+IDX_W-1:0] rom_addr;
    logic [7:0]         rom_data;
    logic [4:0]         note;
    logic               note_on;
    logic               busy;
    logic [IDX_W-1:0]   note_idx;
    logic               done;

    int passed = 0;
    int total  = 0;

    song_play_ctrl #(
        .IDX_W(IDX_W), .BEAT_UNIT(4), .GAP_CYCLES(2), .PLAY_STATE(3'b010)
    ) dut (
        .clk(clk), .rst(rst), .state(state), .song_id(song_id), .song_len(song_len),
        .start(start), .pause(pause), .rom_addr(rom_addr), .rom_data(rom_data),
        .note(note), .note_on(note_on), .busy(busy), .note_idx(note_idx), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Song 1: {note 5, len 1}, {note 3, len 0}; song 2: {rest, len 2}
    function automatic logic [7:0] rom_f(input logic [16:0] a);
        case (a)
            {8'd1, 9'd0}: rom_f = 8'h29;
            {8'd1, 9'd1}: rom_f = 8'h18;
            {8'd2, 9'd0}: rom_f = 8'h02;
            default:      rom_f = 8'hFF;
        endcase
    endfunction

    always @(posedge clk) rom_data <= rom_f(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_start(input logic [7:0] id, input logic [IDX_W-1:0] len);
        start    = 1'b1;
        song_id  = id;
        song_len = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Full unpaused run of song 1, cycle by cycle from the accepting edge
    task automatic play_song1(input string tag);
        logic e_on, e_busy, e_done;
        logic [4:0] e_note;
        do_start(8'd1, 9'd2);
        for (int c = 1; c <= 22; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 2) song_id = 8'd9;
            #1;
            e_on = (c >= 3 && c <= 10) || (c >= 15 && c <= 18);
            e_note = (c >= 3 && c <= 12) ? 5'd5 : (c >= 15 && c <= 20) ? 5'd3 : 5'd0;
            e_busy = (c <= 21);
            e_done = (c == 21);
            chk($sformatf("%s_on_c%0d", tag, c), note_on, e_on);
            chk($sformatf("%s_note_c%0d", tag, c), note, e_note);
            chk($sformatf("%s_busy_c%0d", tag, c), busy, e_busy);
            chk($sformatf("%s_done_c%0d", tag, c), done, e_done);
            if (c == 1)  chk($sformatf("%s_addr0", tag), rom_addr, {8'd1, 9'd0});
            if (c == 13) chk($sformatf("%s_addr1", tag), rom_addr, {8'd1, 9'd1});
            if (c == 13) chk($sformatf("%s_idx1", tag), note_idx, 9'd1);
            if (c == 22) chk($sformatf("%s_idx_end", tag), note_idx, 9'd0);
        end
    endtask

    initial begin
        int hi5, fetch_c, done_c, done_cnt, on_cnt;
        rst = 1'b1; state = 3'b010; song_id = 8'd0; song_len = '0;
        start = 1'b0; pause = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_note_on", note_on, 1'b0);
        chk("rst_addr", rom_addr, 17'd0);
        chk("rst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        play_song1("basic");

        // Pause for 5 cycles starting at the 3rd cycle of the 8-cycle note
        hi5 = 0; fetch_c = 0; done_c = 0;
        do_start(8'd1, 9'd2);
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) @(negedge clk);
            pause = (c >= 5 && c <= 9);
            #1;
            if (note_on && note == 5'd5) hi5++;
            if (pause) begin
                chk($sformatf("pause_on_c%0d", c), note_on, 1'b0);
                chk($sformatf("pause_note_c%0d", c), note, 5'd5);
            end
            if (fetch_c == 0 && c > 1 && rom_addr === {8'd1, 9'd1}) fetch_c = c;
            if (done === 1'b1) done_c = c;
        end
        chk("pause_high_total", hi5, 8);
        chk("pause_fetch_cycle", fetch_c, 18);
        chk("pause_done_cycle", done_c, 26);

        // Abort during the gap after note 0
        done_cnt = 0;
        do_start(8'd1, 9'd2);
        for (int c = 1; c <= 15; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 11) state = 3'b111;
            #1;
            if (done === 1'b1) done_cnt++;
            if (c == 11) chk("abort_in_gap", busy, 1'b1);
            if (c == 12) begin
                chk("abort_busy", busy, 1'b0);
                chk("abort_idx", note_idx, 9'd0);
                chk("abort_note", note, 5'd0);
                chk("abort_on", note_on, 1'b0);
            end
        end
        chk("abort_no_done", done_cnt, 0);
        state = 3'b010;
        play_song1("replay");

        // Empty song completes immediately
        do_start(8'd5, 9'd0);
        #1;
        chk("len0_done", done, 1'b1);
        chk("len0_busy", busy, 1'b1);
        chk("len0_on", note_on, 1'b0);
        @(negedge clk); #1;
        chk("len0_done_clear", done, 1'b0);
        chk("len0_idle", busy, 1'b0);

        // Rest note with a start pulse while busy
        on_cnt = 0; done_c = 0;
        do_start(8'd2, 9'd1);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            start = (c == 5);
            if (c == 5) begin song_id = 8'd1; song_len = 9'd2; end
            #1;
            if (note_on) on_cnt++;
            if (done === 1'b1) done_c = c;
            if (c == 8) chk("rest_addr", rom_addr, {8'd2, 9'd0});
            if (c == 10) chk("rest_note", note, 5'd0);
            if (c == 18) chk("rest_idle", busy, 1'b0);
        end
        chk("rest_on_count", on_cnt, 0);
        chk("rest_done_cycle", done_c, 17);

        // Start outside AUTOPLAY is ignored
        state = 3'b001;
        do_start(8'd1, 9'd2);
        #1;
        chk("wrong_state_busy", busy, 1'b0);
        state = 3'b010;

        // Asynchronous reset in the middle of a note
        @(negedge clk);
        do_start(8'd1, 9'd2);
        for (int c = 2; c <= 5; c++) @(negedge clk);
        #1;
        chk("pre_rst_on", note_on, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_on", note_on, 1'b0);
        chk("arst_note", note, 5'd0);
        chk("arst_idx", note_idx, 9'd0);
        chk("arst_addr", rom_addr, 17'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            chk($sformatf("post_rst_idle_c%0d", c), busy, 1'b0);
        end
        play_song1("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/song_play_ctrl.md
Name: song_play_ctrl

Overview:
- Playback sequencer for AUTOPLAY mode. Latches the chosen song_id, then walks that song's note ROM one entry at a time.
- Times each note's duration plus an inter-note gap, and drives the note code to the tone generator.
- Sits between the song-selection logic (song_id source) and the buzzer/tone datapath. Supports pause, abort on mode change, and an end-of-song pulse.

Parameters:
- IDX_W, 9, note index width; max song length 2^IDX_W-1 notes.
- BEAT_UNIT, 1600, clock cycles per duration unit (base beat).
- GAP_CYCLES, 2800, silent cycles after every note.
- PLAY_STATE, 3'b010, value of state input that enables playback (AUTOPLAY).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- state  in  3  top-level mode code
- song_id  in  8  selected song, sampled only on accepted start
- song_len  in  IDX_W  number of notes in the selected song, sampled with song_id
- start  in  1  single-cycle start request
- pause  in  1  level; freezes timing and silences output
- rom_addr  out  8+IDX_W  {song_id_latched, note_idx}
- rom_data  in  8  [7:3] note code (0 = rest), [2:0] length code; valid one cycle after rom_addr
- note  out  5  current note code to tone generator
- note_on  out  1  tone generator enable
- busy  out  1  high in every state except IDLE
- note_idx  out  IDX_W  index of note being fetched or played
- done  out  1  one-cycle pulse at natural end of song

Behaviour:
- Reset (async, rst=1): FSM=IDLE; rom_addr=0, note=0, note_on=0, busy=0, note_idx=0, done=0; all counters and latches 0.
- FSM states: IDLE, FETCH, LOAD, PLAY, GAP, DONE. Registered, one transition per clk edge.
- IDLE:
  - start=1 and state==PLAY_STATE at an edge: latch song_id and song_len, note_idx=0.
  - Next state is FETCH, or DONE if song_len==0.
  - start is ignored while busy.
- FETCH: rom_addr driven with {song_id_latched, note_idx}. Next state LOAD.
- LOAD: capture rom_data into note_code/len_code. Load unit_cnt=BEAT_UNIT-1, units_left=len_code. Next state PLAY.
- PLAY:
  - note=note_code; note_on=(note_code!=0) && !pause.
  - unit_cnt counts down. At 0 with units_left>0: decrement units_left, reload unit_cnt.
  - At 0 with units_left==0: go to GAP with gap_cnt=GAP_CYCLES-1.
  - PLAY lasts exactly (len_code+1)*BEAT_UNIT unpaused cycles.
- GAP:
  - note_on=0; note holds the last code.
  - When gap_cnt reaches 0: note_idx+1; next state DONE if note_idx+1==song_len, else FETCH.
  - GAP lasts exactly GAP_CYCLES unpaused cycles.
- DONE: done=1 for this single cycle; note=0, note_on=0; note_idx reset to 0. Next state IDLE.
- Unpaused note period: 2 + (len_code+1)*BEAT_UNIT + GAP_CYCLES cycles.
- Latency: start accepted at edge N → FETCH in cycle N+1, LOAD N+2, note_on first high cycle N+3 (non-rest note).
- Pause (level):
  - In PLAY/GAP: all counters hold; note_on=0. Resuming continues from the held count with no cycle lost or added.
  - In FETCH/LOAD: no effect; the FSM enters PLAY already frozen.
- Abort: state!=PLAY_STATE in any non-IDLE state → next edge IDLE, note=0, note_on=0, note_idx=0.
  - done is not pulsed on abort.
  - Abort has priority over pause and over the normal transition in the same cycle.
- song_id/song_len changes while busy have no effect until the next accepted start.
- Rest (code 0): full duration timed, note_on stays 0.
- Last note: GAP is still executed before DONE.
- note_idx never wraps: song_len ≤ 2^IDX_W-1 is required of the source.

Test Plan:
- Basic flow, BEAT_UNIT=4, GAP_CYCLES=2, song_len=2, ROM {note 5, len 1} then {note 3, len 0}:
  - note_on high 8 cycles with note=5, low 2+2 cycles, high 4 cycles with note=3, low 2 cycles.
  - done pulses once; busy falls the cycle after done.
- Start latency: start at edge N → rom_addr={song_id,0} in cycle N+1; note_on rises in cycle N+3.
- Pause mid-note: assert pause for 5 cycles at cycle 3 of an 8-cycle note → note_on low 5 cycles, note still 5. Total high time stays 8; the next FETCH is delayed by exactly 5 cycles.
- Abort: drop state to 3'b111 during GAP of note 0 → next cycle IDLE, busy=0, note_idx=0, done never asserted. A subsequent start replays from index 0.
- Edge cases:
  - song_len=0 → start gives done one cycle after acceptance, no ROM fetch.
  - Rest note (code 0, len 2) → note_on low 12+2 cycles.
  - start pulsed while busy → ignored, song_id unchanged.
- Async reset asserted mid-PLAY, not on a clock edge → all outputs 0 immediately. FSM stays IDLE after release until a new start.
